// File: rtl/rvm_mem_responder.sv
// ---------------------------------------------------------------------------
// rvm_mem_responder
//
// Memory-side responder for the core's multi-cycle memory request interface.
// Word-organised synchronous RAM with byte-enable writes, a programmable
// number of wait states between accept and response, and a single
// outstanding transaction. Serves instruction fetch, loads and stores.
//
// Optional feature (compile-time macro RVM_MEM_RESP_ERR_EN):
//   defined   - misaligned or out-of-window addresses fault: mem_error=1 on
//               the ack, writes are suppressed, reads return 0.
//   undefined - mem_error tied to 0, addr[1:0] ignored, addresses alias
//               modulo the RAM depth.
//
// Ports:
//   clk        in   1   system clock
//   resetn     in   1   asynchronous active-low reset
//   mem_req    in   1   transfer request, held until mem_gnt
//   mem_wen    in   1   1 = write, 0 = read
//   mem_addr   in  32   byte address
//   mem_wdata  in  32   write data
//   mem_ben    in   4   byte enables, bit i covers bits 8i+7:8i
//   mem_gnt    out  1   request accepted this cycle (combinational, IDLE only)
//   mem_ack    out  1   one-cycle response strobe
//   mem_rdata  out 32   read data, valid while mem_ack
//   mem_error  out  1   transaction faulted, valid while mem_ack
// ---------------------------------------------------------------------------
module rvm_mem_responder #(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WAIT_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_ben,
    output logic        mem_gnt,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int         IDX_W     = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]       r_cnt;

    // Transaction captured at accept time
    logic             r_wen;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_ben;
    logic             r_err;

    logic [31:0]      r_mem [MEM_DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;

    // Operands of the access performed on the edge entering RESP
    logic             w_acc_wen;
    logic [IDX_W-1:0] w_acc_idx;
    logic [31:0]      w_acc_wdata;
    logic [3:0]       w_acc_ben;
    logic             w_acc_err;

    // Word index: the cast keeps only the low IDX_W bits, which gives the
    // modulo-depth aliasing for out-of-window addresses.
    assign w_idx = IDX_W'((mem_addr - BASE_ADDR) >> 2);

`ifdef RVM_MEM_RESP_ERR_EN
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH_WORDS);

    assign w_err = (mem_addr[1:0] != 2'b00) ||
                   (mem_addr < BASE_ADDR) ||
                   ({1'b0, mem_addr} >= END_ADDR);
`else
    assign w_err = 1'b0;
`endif

    assign w_accept = resetn && (r_state == S_IDLE) && mem_req;

    // With zero wait states the access happens on the accept edge itself,
    // before the captured registers are loaded, so take the live inputs.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_wen   = mem_wen;
            w_acc_idx   = w_idx;
            w_acc_wdata = mem_wdata;
            w_acc_ben   = mem_ben;
            w_acc_err   = w_err;
        end else begin
            w_acc_wen   = r_wen;
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
            w_acc_ben   = r_ben;
            w_acc_err   = r_err;
        end
    end

    assign w_enter_resp = resetn && (w_next == S_RESP) && (r_state != S_RESP);

    // State register and wait counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= WAIT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_gnt = w_accept;
        mem_ack = (r_state == S_RESP);
    end

    // Request capture; data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wen   <= mem_wen;
            r_idx   <= w_idx;
            r_wdata <= mem_wdata;
            r_ben   <= mem_ben;
            r_err   <= w_err;
        end
    end

    // RAM write port; gated by resetn so a reset landing on the commit edge
    // never performs a dropped write. Contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_acc_wen && !w_acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_ben[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared on the
    // edge leaving it, so they are stable for exactly the ack cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end else if (w_enter_resp) begin
            mem_rdata <= (w_acc_wen || w_acc_err) ? 32'd0 : r_mem[w_acc_idx];
            mem_error <= w_acc_err;
        end else if (r_state == S_RESP) begin
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvm_mem_responder.sv
module tb_rvm_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int w, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL w%0d %s got=%h want=%h", w, nm, got, exp);
        end
    endfunction

    // Three instances with different wait-state counts share the clock.
    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        logic        rstn, req, wen, gnt, ack, err;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  ben;
        bit          done_g = 1'b0;

        rvm_mem_responder #(
            .MEM_DEPTH_WORDS(DEPTH),
            .BASE_ADDR      (BASE),
            .WAIT_CYCLES    (W)
        ) u_dut (
            .clk      (clk),
            .resetn   (rstn),
            .mem_req  (req),
            .mem_wen  (wen),
            .mem_addr (addr),
            .mem_wdata(wdata),
            .mem_ben  (ben),
            .mem_gnt  (gnt),
            .mem_ack  (ack),
            .mem_rdata(rdata),
            .mem_error(err)
        );

        // Reference model: word array plus one pending transaction.
        logic [31:0] mm [DEPTH];
        bit          pend = 1'b0;
        int          ack_at;
        bit          p_w;
        logic [31:0] p_a, p_d;
        logic [3:0]  p_b;

        function automatic bit addr_err(logic [31:0] a);
`ifdef RVM_MEM_RESP_ERR_EN
            return (a[1:0] != 2'b00) || (a < BASE) ||
                   ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * DEPTH)));
`else
            return 1'b0;
`endif
        endfunction

        function automatic int widx(logic [31:0] a);
            return int'(((a - BASE) >> 2) % DEPTH);
        endfunction

        // Compare process
        always @(negedge clk) begin
            bit          eg, ea, ee;
            logic [31:0] er;
            int          i;
            if (!rstn) begin
                pend = 1'b0;
                chk("rst_gnt", W, {31'd0, gnt}, 32'd0);
                chk("rst_ack", W, {31'd0, ack}, 32'd0);
                chk("rst_rdata", W, rdata, 32'd0);
                chk("rst_err", W, {31'd0, err}, 32'd0);
            end else begin
                ea = pend && (cyc == ack_at);
                eg = req && !pend;
                er = 32'd0;
                ee = 1'b0;
                if (ea) begin
                    i  = widx(p_a);
                    ee = addr_err(p_a);
                    if (!ee) begin
                        if (!p_w) begin
                            er = mm[i];
                        end else begin
                            for (int b = 0; b < 4; b++)
                                if (p_b[b]) mm[i][8*b +: 8] = p_d[8*b +: 8];
                        end
                    end
                end
                chk("gnt", W, {31'd0, gnt}, {31'd0, eg});
                chk("ack", W, {31'd0, ack}, {31'd0, ea});
                chk("rdata", W, rdata, er);
                chk("err", W, {31'd0, err}, {31'd0, ee});
                if (ea) pend = 1'b0;
                if (eg) begin
                    pend   = 1'b1;
                    ack_at = cyc + 1 + W;
                    p_w    = wen;
                    p_a    = addr;
                    p_d    = wdata;
                    p_b    = ben;
                end
            end
        end

        task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input bit keep,
                           output logic [31:0] rd, output logic er,
                           output int gc, output int ac);
            int n;
            rd = 32'hx; er = 1'bx; gc = -1; ac = -1;
            @(posedge clk); #1;
            req = 1'b1; wen = w; addr = a; wdata = d; ben = b;
            n = 0;
            do begin @(negedge clk); n++; end while (!gnt && n < 64);
            if (!gnt) begin
                total++; bad++;
                $display("FAIL w%0d gnt_timeout got=0 want=1", W);
                req = 1'b0;
            end else begin
                gc = cyc;
                @(posedge clk); #1;
                if (!keep) req = 1'b0;
                n = 0;
                while (!ack && n < 64) begin @(negedge clk); n++; end
                if (!ack) begin
                    total++; bad++;
                    $display("FAIL w%0d ack_timeout got=0 want=1", W);
                end else begin
                    rd = rdata; er = err; ac = cyc;
                end
            end
        endtask

        task automatic txn_rst(input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b);
            int n;
            @(posedge clk); #1;
            req = 1'b1; wen = w; addr = a; wdata = d; ben = b;
            n = 0;
            do begin @(negedge clk); n++; end while (!gnt && n < 64);
            if (!gnt) begin
                total++; bad++;
                $display("FAIL w%0d rgnt_timeout got=0 want=1", W);
            end
            @(posedge clk); #1;
            req  = 1'b0;
            rstn = 1'b0;
            repeat (2) @(posedge clk);
            #1 rstn = 1'b1;
        endtask

        initial begin
            logic [31:0] rd, rd2;
            logic        er, er2;
            int          gc, ac, gc2, ac2;
            rstn = 1'b0; req = 1'b0; wen = 1'b0; addr = '0; wdata = '0; ben = '0;
            repeat (2) @(posedge clk);
            req = 1'b1;
            @(negedge clk);
            chk("lit_rst_gnt", W, {31'd0, gnt}, 32'd0);
            chk("lit_rst_ack", W, {31'd0, ack}, 32'd0);
            @(posedge clk); #1;
            req = 1'b0; rstn = 1'b1;

            for (int k = 0; k < DEPTH; k++)
                txn(1'b1, BASE + 32'(4 * k), $urandom, 4'hF, 1'b0, rd, er, gc, ac);

            txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, gc, ac);
            txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
            chk("lit_rd_beef", W, rd, 32'hDEADBEEF);
            chk("lit_err0", W, {31'd0, er}, 32'd0);
            chk("lit_latency", W, 32'(ac - gc), 32'(1 + W));

            txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, er, gc, ac);
            txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, gc, ac);
            chk("lit_wr_rdata0", W, rd, 32'd0);
            txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
            chk("lit_merge", W, rd, 32'h11BB33DD);

            txn(1'b1, 32'h24, 32'h0, 4'b0000, 1'b0, rd, er, gc, ac);

            txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gc, ac);
            txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd2, er2, gc2, ac2);
            chk("lit_hold_rd1", W, rd, 32'hDEADBEEF);
            chk("lit_hold_rd2", W, rd2, 32'h11BB33DD);
            chk("lit_hold_gap", W, 32'(gc2 - ac), 32'd1);

            txn(1'b1, BASE, 32'hCAFE0001, 4'hF, 1'b0, rd, er, gc, ac);
`ifdef RVM_MEM_RESP_ERR_EN
            txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
            chk("lit_mis_err", W, {31'd0, er}, 32'd1);
            chk("lit_mis_rd", W, rd, 32'd0);
            txn(1'b1, BASE + 32'(4 * DEPTH), 32'h5, 4'hF, 1'b0, rd, er, gc, ac);
            chk("lit_oor_err", W, {31'd0, er}, 32'd1);
            txn(1'b0, BASE, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
            chk("lit_oor_word0", W, rd, 32'hCAFE0001);
`else
            txn(1'b1, BASE + 32'(4 * DEPTH), 32'h5, 4'hF, 1'b0, rd, er, gc, ac);
            chk("lit_alias_err", W, {31'd0, er}, 32'd0);
            txn(1'b0, BASE, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
            chk("lit_alias_rd", W, rd, 32'h5);
            chk("lit_alias_err2", W, {31'd0, er}, 32'd0);
`endif

            if (W > 0) begin
                txn_rst(1'b1, 32'h10, 32'h12345678, 4'hF);
                txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, gc, ac);
                chk("lit_rst_keep", W, rd, 32'hDEADBEEF);
            end

            for (int k = 0; k < 150; k++) begin
                txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 8 * DEPTH - 1)),
                    $urandom, 4'($urandom_range(0, 15)),
                    (k < 149) ? 1'($urandom_range(0, 1)) : 1'b0,
                    rd, er, gc, ac);
            end
            done_g = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(gi[0].done_g && gi[1].done_g && gi[2].done_g) && n < 50000) begin
            @(posedge clk);
            n++;
        end
        if (!(gi[0].done_g && gi[1].done_g && gi[2].done_g)) begin
            total++; bad++;
            $display("FAIL run_timeout got=0 want=1");
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvm_mem_responder.md
Name: rvm_mem_responder

Overview:
- Memory-side responder for the core's multi-cycle memory request interface; the other end of the requests the control FSM issues for instruction fetch, loads and stores.
- Word-organised synchronous RAM with byte-enable writes, configurable wait states and a single outstanding transaction.
- Used as the simulation/FPGA memory model beneath the core.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned.
- WAIT_CYCLES, 1, extra cycles between accept and response; 0..15.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- mem_req  input  1  core requests a transfer; held high until mem_gnt.
- mem_wen  input  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_ben  input  4  byte enables; bit i = bits 8i+7:8i.
- mem_gnt  output  1  request accepted this cycle.
- mem_ack  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data, valid while mem_ack.
- mem_error  output  1  transaction faulted, valid while mem_ack.

Behaviour:
- Reset (already decided): resetn asynchronous, active-low; clock clk. While resetn is low: FSM = IDLE, wait counter = 0, mem_ack = 0, mem_rdata = 0, mem_error = 0, mem_gnt = 0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_gnt = mem_req (combinational; only in IDLE).
  - On a clock edge with mem_req high, latch addr/wdata/ben/wen and load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: counter decrements each cycle; go to RESP on the edge where counter reaches 1. mem_gnt = 0.
- RESP:
  - mem_ack = 1 for exactly one cycle, with mem_rdata and mem_error registered (stable for the whole ack cycle).
  - Next state is always IDLE. A new request can be granted the cycle after the ack.
- Latency: request granted at cycle T -> mem_ack at cycle T+1+WAIT_CYCLES. Throughput is one transaction per 2+WAIT_CYCLES cycles.
- mem_req seen outside IDLE: ignored, gnt stays 0, no state change. The core must hold mem_req until granted.
- Read: mem_rdata = RAM[(addr-BASE_ADDR)>>2], sampled on the edge entering RESP.
- Write:
  - Each byte lane with ben[i]=1 is updated on the edge entering RESP; lanes with ben[i]=0 are unchanged.
  - mem_rdata = 0 on write acks. ben = 4'b0000 is a legal no-op write that still acks.
- Read-after-write to the same word returns the new data, with no forwarding hazard, since transactions are serialised.
- Address index is truncated to log2(MEM_DEPTH_WORDS) bits.
- Reset asserted mid-transaction: the transaction is dropped, no ack is issued, and a write not yet committed is not performed.
- mem_rdata and mem_error return to 0 in the cycle after the ack.

Optional Feature:
- Macro: RVM_MEM_RESP_ERR_EN.
- Defined:
  - mem_error = 1 on ack if addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + 4*MEM_DEPTH_WORDS.
  - Faulting writes do not modify the RAM; faulting reads return mem_rdata = 0.
  - Latency is unchanged.
- Undefined:
  - mem_error is tied to 0 and addr[1:0] is ignored.
  - Out-of-range addresses alias modulo the depth (index = ((addr-BASE_ADDR)>>2) mod MEM_DEPTH_WORDS).

Test Plan:
- WAIT_CYCLES=1: write 32'hDEADBEEF to 0x10 with ben=4'hF, then read 0x10 -> gnt at T, ack at T+2, second ack shows rdata=32'hDEADBEEF, error=0.
- Byte merge: word 0x20 holds 32'h11223344; write 32'hAABBCCDD with ben=4'b0101; read 0x20 -> 32'h11BB33DD.
- WAIT_CYCLES=3: read request held high -> gnt 1 cycle, ack exactly 4 cycles after gnt. mem_req kept high through the ack -> next gnt in the cycle after the ack, not before.
- RVM_MEM_RESP_ERR_EN defined:
  - read 0x13 -> ack with error=1, rdata=0.
  - write to BASE_ADDR+4*MEM_DEPTH_WORDS -> error=1, and a follow-up read of word 0 is unchanged.
- Macro undefined: write 32'h5 to BASE_ADDR+4*MEM_DEPTH_WORDS, read 0x0 -> 32'h5, error=0.
- Reset mid-op: write granted, resetn pulsed low during WAIT -> no ack, outputs 0. After release, a read of that address returns the old data.
